pipe_skid_stage: RTL

Parametrised, elastic pipeline stage register for the five-stage MIPS pipeline, replacing fixed-width, clear-only stage latches between D/E/M/W. It carries an arbitrary-width payload (instruction word plus side-band flags) under a valid/ready handshake. A two-entry skid buffer sustains one transfer per cycle without a combinational path from `out_ready` to `in_ready`. It also supports synchronous flush to a configurable NOP and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_skid_stage.sv | 90 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers between D/E/M/W.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready stage register with a two-entry skid buffer, flush to NOP
// and a saturating stall-cycle counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int            DW        = 33,
    parameter logic [DW-1:0] NOP_VALUE = DW'(NOP_INSN),
    parameter int            CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    occ_t          state;
    logic [DW-1:0] skid_data;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // out_data doubles as the main register; in_ready/out_valid are kept as
    // dedicated flops so no input ever reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= NOP_VALUE;
            skid_data <= NOP_VALUE;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_data <= in_data;
                    end else if (out_xfer) begin
                        out_data  <= NOP_VALUE;
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (in_xfer) begin
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= TWO;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        out_data  <= skid_data;
                        skid_data <= NOP_VALUE;
                        in_ready  <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    out_data  <= NOP_VALUE;
                    skid_data <= NOP_VALUE;
                end
            endcase
        end
    end

    // Flush deliberately does not clear the counter: it accumulates across squashes.
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .clr(rst),
        .inc(out_valid & ~out_ready),
        .cnt(stall_cnt)
    );

endmodule
